reg_rr_mux: RTL
===============

// Module: reg_rr_mux
// PURPOSE
//   N-to-1 register-interface multiplexer: arbitrates NoPorts initiators onto one responder port.
//   Round-robin fairness; the grant is held for the whole transaction (valid until ready).
//   Sits upstream of a shared register file/peripheral, or upstream of a reg_demux for N:M fabrics.
//   Zero-latency forward path. The arbitration state (lock, RR pointer) is registered.
// PARAMETERS
//   NoPorts        32'd2   number of initiator ports, >= 1
//   req_t          logic   reg request struct (addr, write, wdata, wstrb, valid)
//   rsp_t          logic   reg response struct (rdata, error, ready)
//   TimeoutCycles  32'd256 watchdog limit in cycles, >= 1; used only with REG_RR_MUX_TIMEOUT_EN
//   SelectWidth    derived (NoPorts>1 ? $clog2(NoPorts) : 1); do not override
// PORTS
//   clk_i      in   1            clock
//   rst_ni     in   1            asynchronous reset, active low
//   in_req_i   in   NoPorts*req  initiator requests
//   in_rsp_o   out  NoPorts*rsp  initiator responses
//   out_req_o  out  req          request to responder
//   out_rsp_i  in   rsp          response from responder
//   out_sel_o  out  SelectWidth  index of the port currently forwarded
// BEHAVIOUR
// - Handshake: a transaction completes in the cycle where out valid && out_rsp_i.ready.
//   The initiator holds its request stable until it sees ready.
// - State: IDLE / BUSY, plus registers rr_q (next priority), gnt_q (locked port).
//   rr_q and gnt_q are SelectWidth wide.
// - Reset: state=IDLE, rr_q=0, gnt_q=0.
//   Outputs while in reset: out_req_o='0, every in_rsp_o='0, out_sel_o=0.
// - IDLE, no valid input:
//   out_req_o='0, out_sel_o=rr_q.
// - IDLE, any valid input:
//   - Combinationally pick gnt = first valid port scanning rr_q, rr_q+1, ..., wrapping NoPorts-1 -> 0.
//   - out_req_o = in_req_i[gnt]; out_sel_o = gnt.
//   - If ready arrives in the same cycle: transaction done, stay IDLE, rr_q <= gnt+1 mod NoPorts.
//   - Otherwise: go to BUSY and set gnt_q <= gnt.
// - BUSY:
//   - Forward in_req_i[gnt_q]; other requests are ignored even if valid.
//   - On ready: go to IDLE and set rr_q <= gnt_q+1 mod NoPorts.
//     The new arbitration round starts next cycle (no back-to-back grant in the completion cycle).
// - Responses:
//   - in_rsp_o[sel] = out_rsp_i; all other in_rsp_o = '0 (ready=0).
//   - Non-granted initiators stall indefinitely; there is no error for them.
// - Granted initiator drops valid in BUSY (protocol violation):
//   - out valid=0 that cycle; next state is IDLE; rr_q is unchanged.
//   - Simulation assertion fires.
// - rr_q advances only on completion. A completion is never lost on wrap-around.
// - NoPorts==1: out_req_o=in_req_i[0], in_rsp_o[0]=out_rsp_i.
//   out_sel_o=0; the FSM is kept but is functionally transparent.
// - Mid-transaction reset: aborts immediately to the reset values; no response is issued.
// CONFIGURATION
// - REG_RR_MUX_TIMEOUT_EN defined:
//   - A cnt_q counter (width $clog2(TimeoutCycles+1)) clears on entering BUSY and increments each BUSY cycle.
//   - When cnt_q == TimeoutCycles-1 without ready:
//     - in_rsp_o[gnt_q] = {rdata:'0, error:1, ready:1} for one cycle.
//     - out valid is forced to 0 in that cycle.
//     - Next state is IDLE; rr_q <= gnt_q+1.
//   - If ready and the timeout occur in the same cycle, the real response wins (no error).
// - REG_RR_MUX_TIMEOUT_EN undefined:
//   - No counter; BUSY waits for ready forever.
//   - TimeoutCycles is ignored.
// TESTING
//   1. NoPorts=4, reset, ports 1 and 3 valid, ready=1 each cycle:
//      grants 1, 3, 1, 3; out_sel_o follows; each in_rsp_o ready only on its own grant.
//   2. NoPorts=4, all valid, ready delayed 3 cycles per txn:
//      order 0, 1, 2, 3, 0; out_req_o constant while BUSY; other ports see ready=0.
//   3. Port 3 completes, then only port 0 valid:
//      rr_q wraps to 0 and port 0 is granted with no idle bubble beyond the completion cycle.
//   4. Port 2 valid with write=1, addr=0x40; drop valid after 1 cycle in BUSY:
//      assertion fires, FSM returns to IDLE, rr_q unchanged.
//   5. Macro on, TimeoutCycles=8, no ready:
//      port 1 receives error=1, ready=1 on the 8th BUSY cycle; next grant is port 2.
//   6. rst_ni asserted while BUSY on port 2:
//      outputs are '0 immediately; after release, rr_q=0 and port 0 wins if valid.

Source files
------------

// File: rtl/reg_rr_mux.sv
// Round-robin N:1 register-interface mux; the grant is held from valid until ready.
// Optional watchdog that answers a stuck transaction with an error: REG_RR_MUX_TIMEOUT_EN.
package reg_rr_mux_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module reg_rr_mux #(
  parameter int unsigned NoPorts       = 32'd2,
  parameter type         req_t         = reg_rr_mux_pkg::reg_req_t,
  parameter type         rsp_t         = reg_rr_mux_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 32'd256,
  parameter int unsigned SelectWidth   = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  req_t [NoPorts-1:0]     in_req_i,
  output rsp_t [NoPorts-1:0]     in_rsp_o,
  output req_t                   out_req_o,
  input  rsp_t                   out_rsp_i,
  output logic [SelectWidth-1:0] out_sel_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_d, state_q;
  logic [SelectWidth-1:0] rr_d, rr_q, gnt_d, gnt_q;
  logic [SelectWidth-1:0] arb_sel, sel;
  logic                   any_valid, fwd_valid, timeout;
  int unsigned            idx;

  function automatic logic [SelectWidth-1:0] inc_idx(input logic [SelectWidth-1:0] i);
    if (32'(i) == NoPorts - 1) return '0;
    return i + 1'b1;
  endfunction

  // First valid port at or after rr_q, wrapping.
  always_comb begin
    any_valid = 1'b0;
    arb_sel   = rr_q;
    idx       = 0;
    for (int unsigned i = 0; i < NoPorts; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NoPorts) idx = idx - NoPorts;
      if (!any_valid && in_req_i[idx[SelectWidth-1:0]].valid) begin
        any_valid = 1'b1;
        arb_sel   = idx[SelectWidth-1:0];
      end
    end
  end

`ifdef REG_RR_MUX_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_d, cnt_q;

  // A real ready in the same cycle beats the watchdog.
  assign timeout = (state_q == BUSY) && in_req_i[gnt_q].valid && !out_rsp_i.ready &&
                   (cnt_q == CntWidth'(TimeoutCycles - 1));
  assign cnt_d   = (state_q == BUSY) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    sel       = rr_q;
    fwd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          sel       = arb_sel;
          fwd_valid = 1'b1;
          if (out_rsp_i.ready) begin
            rr_d = inc_idx(arb_sel);
          end else begin
            state_d = BUSY;
            gnt_d   = arb_sel;
          end
        end
      end
      BUSY: begin
        sel       = gnt_q;
        fwd_valid = in_req_i[gnt_q].valid && !timeout;
        if (!in_req_i[gnt_q].valid) begin
          state_d = IDLE;
        end else if (out_rsp_i.ready || timeout) begin
          state_d = IDLE;
          rr_d    = inc_idx(gnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_req_o = '0;
    in_rsp_o  = '0;
    out_sel_o = sel;
    if (fwd_valid || state_q == BUSY) begin
      out_req_o       = in_req_i[sel];
      out_req_o.valid = fwd_valid;
    end
    in_rsp_o[sel] = out_rsp_i;
    if (timeout) begin
      in_rsp_o[gnt_q]       = '0;
      in_rsp_o[gnt_q].error = 1'b1;
      in_rsp_o[gnt_q].ready = 1'b1;
    end
    // Nothing leaks out while reset is held, even with live requests.
    if (!rst_ni) begin
      out_req_o = '0;
      in_rsp_o  = '0;
      out_sel_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (NoPorts >= 1 && TimeoutCycles >= 1)
        else $warning("reg_rr_mux: NoPorts and TimeoutCycles must be >= 1");
      if (state_q == BUSY)
        assert (in_req_i[gnt_q].valid)
          else $warning("reg_rr_mux: port %0d dropped valid before ready", gnt_q);
    end
  end
`endif

endmodule
